sdf_stage4_r2: RTL and testbench



---
 rtl/sdf_stage4_r2.sv | 93 +++++++++
 tb/tb_sdf_stage4_r2.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sdf_stage4_r2.sv
// Radix-2 SDF DIF stage 4 of the 32-point streaming FFT: 2-deep feedback delay,
// butterfly, and W32^0 / W32^8 twiddle multiply on the difference outputs.
module sdf_stage4_r2 #(
    parameter int DATA_W   = 16,
    parameter int WORD_LEN = 11
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data_re,
    input  logic signed [DATA_W-1:0] i_data_im,
    output logic                     o_valid,
    output logic signed [DATA_W:0]   o_data_re,
    output logic signed [DATA_W:0]   o_data_im
);

    localparam int DW = DATA_W + 1;
    localparam int PW = DATA_W + WORD_LEN + 1;

    logic [1:0]           cnt;
    logic                 primed;
    logic signed [DW-1:0] dl0_re, dl0_im, dl1_re, dl1_im;
    logic signed [DW-1:0] x_re, x_im;
    logic signed [DW-1:0] sum_re, sum_im, diff_re, diff_im;
    logic signed [DW-1:0] mul_re, mul_im;
    logic signed [WORD_LEN-1:0] tw_re, tw_im;
    logic signed [PW-1:0] a, b, wr, wi, prod_re, prod_im;

    assign x_re = DW'(i_data_re);
    assign x_im = DW'(i_data_im);

    // dl1 is the oldest entry, i.e. the value popped this sample
    assign sum_re  = dl1_re + x_re;
    assign sum_im  = dl1_im + x_im;
    assign diff_re = dl1_re - x_re;
    assign diff_im = dl1_im - x_im;

    // ROM4: addr 0 -> 1023 + j0, addr 1 -> 0 - j1024 (Q1.10)
    always_comb begin
        tw_re = '0;
        tw_im = '0;
        if (cnt[0])
            tw_im = WORD_LEN'(-1024);
        else
            tw_re = WORD_LEN'(1023);
    end

    always_comb begin
        a       = PW'(dl1_re);
        b       = PW'(dl1_im);
        wr      = PW'(tw_re);
        wi      = PW'(tw_im);
        prod_re = a * wr - b * wi + PW'(512);
        prod_im = a * wi + b * wr + PW'(512);
        mul_re  = DW'(prod_re >>> 10);
        mul_im  = DW'(prod_im >>> 10);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            primed    <= 1'b0;
            dl0_re    <= '0;
            dl0_im    <= '0;
            dl1_re    <= '0;
            dl1_im    <= '0;
            o_valid   <= 1'b0;
            o_data_re <= '0;
            o_data_im <= '0;
        end else if (i_valid) begin
            cnt    <= cnt + 2'd1;
            dl1_re <= dl0_re;
            dl1_im <= dl0_im;
            if (cnt[1]) begin
                dl0_re    <= diff_re;
                dl0_im    <= diff_im;
                o_data_re <= sum_re;
                o_data_im <= sum_im;
            end else begin
                dl0_re    <= x_re;
                dl0_im    <= x_im;
                o_data_re <= mul_re;
                o_data_im <= mul_im;
            end
            if (cnt == 2'd2)
                primed <= 1'b1;
            o_valid <= cnt[1] | primed;
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdf_stage4_r2.sv
// Bench for sdf_stage4_r2: directed groups plus random stimulus against a
// group-based reference model of the radix-2 butterfly and twiddle multiply.
module tb_sdf_stage4_r2;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_valid = 1'b0;
    logic signed [15:0] i_data_re = '0;
    logic signed [15:0] i_data_im = '0;
    logic               o_valid;
    logic signed [16:0] o_data_re;
    logic signed [16:0] o_data_im;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state: samples since reset, current and previous group
    int     k;
    longint cur_re[4], cur_im[4], prv_re[4], prv_im[4];
    longint last_re, last_im;
    longint obs_re[$], obs_im[$];

    sdf_stage4_r2 #(.DATA_W(16), .WORD_LEN(11)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_data_re(i_data_re),
        .i_data_im(i_data_im),
        .o_valid  (o_valid),
        .o_data_re(o_data_re),
        .o_data_im(o_data_im)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        k       = 0;
        last_re = 0;
        last_im = 0;
        for (int i = 0; i < 4; i++) begin
            cur_re[i] = 0; cur_im[i] = 0; prv_re[i] = 0; prv_im[i] = 0;
        end
    endtask

    task automatic step(input bit v, input int re, input int im);
        bit     ev;
        longint er, ei, dr, di, wr, wi;
        int     pos;
        i_valid   = v;
        i_data_re = 16'(re);
        i_data_im = 16'(im);
        @(posedge i_clk);
        #1;
        ev = 1'b0; er = last_re; ei = last_im;
        if (v) begin
            pos = k % 4;
            if (pos < 2) begin
                if (k >= 4) begin
                    dr = prv_re[pos] - prv_re[pos+2];
                    di = prv_im[pos] - prv_im[pos+2];
                    wr = (pos == 0) ? 1023 : 0;
                    wi = (pos == 0) ? 0 : -1024;
                    er = (dr * wr - di * wi + 512) >>> 10;
                    ei = (dr * wi + di * wr + 512) >>> 10;
                    ev = 1'b1;
                end
            end else begin
                er = cur_re[pos-2] + longint'(re);
                ei = cur_im[pos-2] + longint'(im);
                ev = 1'b1;
            end
            cur_re[pos] = re;
            cur_im[pos] = im;
            if (pos == 3) begin
                prv_re = cur_re;
                prv_im = cur_im;
            end
            k++;
        end
        check("o_valid", o_valid, ev);
        check("o_data_re", o_data_re, er);
        check("o_data_im", o_data_im, ei);
        if (ev) begin
            last_re = er;
            last_im = ei;
            obs_re.push_back(o_data_re);
            obs_im.push_back(o_data_im);
        end
    endtask

    // asserted between edges so the clear is seen without a clock edge
    task automatic apply_reset();
        i_rst_n = 1'b0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_re", o_data_re, 0);
        check("rst_im", o_data_im, 0);
        for (int i = 0; i < 3; i++) begin
            i_valid   = ~i_valid;
            i_data_re = 16'($urandom);
            i_data_im = 16'($urandom);
            @(posedge i_clk);
            #1;
            check("rst_hold_valid", o_valid, 0);
            check("rst_hold_re", o_data_re, 0);
        end
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        model_reset();
        obs_re.delete();
        obs_im.delete();
    endtask

    initial begin
        int basic_re[6];
        int basic_im[6];
        basic_re = '{400, 600, -200, 0, 0, 0};
        basic_im = '{0, 0, 0, 200, 0, 0};
        model_reset();
        @(posedge i_clk);
        #1;
        apply_reset();

        // basic group, consecutive
        step(1, 100, 0); step(1, 200, 0); step(1, 300, 0); step(1, 400, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        check("basic_count", obs_re.size(), 6);
        for (int i = 0; i < 6 && i < obs_re.size(); i++) begin
            check("basic_re", obs_re[i], basic_re[i]);
            check("basic_im", obs_im[i], basic_im[i]);
        end

        // basic group with a gap after every sample
        apply_reset();
        step(1, 100, 0); step(0, 7, 7); step(1, 200, 0); step(0, -5, 3);
        step(1, 300, 0); step(0, 1, 1); step(1, 400, 0); step(0, 9, 9);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            step(0, 123, -45);
        end
        check("gap_count", obs_re.size(), 6);
        for (int i = 0; i < 6 && i < obs_re.size(); i++) begin
            check("gap_re", obs_re[i], basic_re[i]);
            check("gap_im", obs_im[i], basic_im[i]);
        end

        // W8 exactness
        apply_reset();
        step(1, 0, 0); step(1, 1000, 300); step(1, 0, 0); step(1, 0, 0);
        step(1, 0, 0); step(1, 0, 0);
        check("w8_count", obs_re.size(), 4);
        if (obs_re.size() == 4) begin
            check("w8_re", obs_re[3], 300);
            check("w8_im", obs_im[3], -1000);
        end

        // extremes: no wrap in sum or twiddled difference
        apply_reset();
        step(1, 0, 0); step(1, -32768, -32768); step(1, 0, 0); step(1, 32767, 32767);
        step(1, 0, 0); step(1, 0, 0);
        check("ext_count", obs_re.size(), 4);
        if (obs_re.size() == 4) begin
            check("ext_sum_re", obs_re[1], -1);
            check("ext_sum_im", obs_im[1], -1);
            check("ext_diff_re", obs_re[3], -65535);
            check("ext_diff_im", obs_im[3], 65535);
        end

        // mid-frame reset right after the cnt=2 sample
        apply_reset();
        step(1, 100, 10); step(1, 200, 20); step(1, 300, 30);
        apply_reset();
        step(1, 5, 1); step(1, 6, 2); step(1, 7, 3); step(1, 8, 4);
        step(1, 0, 0); step(1, 0, 0);
        check("mid_count", obs_re.size(), 4);
        if (obs_re.size() == 4) begin
            check("mid_first_re", obs_re[0], 12);
            check("mid_diff0_re", obs_re[2], -2);
        end

        // random traffic with random gaps
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
